regfile_wr_ctrl: RTL and testbench



---
 rtl/regfile_wr_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_regfile_wr_ctrl.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_ctrl.sv
// regfile_wr_ctrl
// ---------------
// Write-port controller for the per-core 20-entry register file. It sits between the
// register file's single write port and three write sources:
//   requester 0 = pipeline writeback
//   requester 1 = memory load return
//   requester 2 = host/debug loader
//
// After reset (or a soft clear) it zero-fills the general-purpose registers 1-14 and 16-18.
// It then grants one source per cycle, round-robin. Writes aimed at the hardwired or
// special registers (0, 15, 19, 20 and 21-31) are accepted but not performed.
//
// Optional feature: define RFWC_DROP_CNT_EN to add the saturating drop_cnt output.
//
// Ports
//   clk        in   clock, all logic on posedge
//   rst        in   asynchronous active-high reset
//   req_valid  in   [2:0]  per-requester write request
//   req_addr   in   [14:0] packed 3x5-bit target register; requester i uses [5i+4:5i]
//   req_data   in   [95:0] packed 3x32-bit write data; requester i uses [32i+31:32i]
//   req_ready  out  [2:0]  per-requester accept, combinational, one-hot or zero
//   clr_req    in   soft-clear request (a pulse is enough), honoured only in RUN
//   wp         out  [4:0]  register-file write address (registered)
//   we         out  register-file write enable (registered)
//   din        out  [31:0] register-file write data (registered)
//   init_done  out  high while running normally, one cycle behind the RUN state
//   err_wr     out  one-cycle pulse after an accepted write was dropped
//   drop_cnt   out  [15:0] saturating dropped-write count (RFWC_DROP_CNT_EN only)

module regfile_wr_ctrl #(
    parameter int unsigned NREQ = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [5*NREQ-1:0] req_addr,
    input  logic [32*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    input  logic              clr_req,
    output logic [4:0]        wp,
    output logic              we,
    output logic [31:0]       din,
    output logic              init_done,
    output logic              err_wr
`ifdef RFWC_DROP_CNT_EN
    ,
    output logic [15:0]       drop_cnt
`endif
);

    typedef enum logic [1:0] {
        StClear = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } state_e;

    // Last general-purpose register filled by the sweep; the sweep skips 15.
    localparam logic [4:0] SweepFirst = 5'd1;
    localparam logic [4:0] SweepLast  = 5'd18;
    localparam logic [4:0] SweepHole  = 5'd15;

    state_e     state_q;
    logic [4:0] ptr_q;
    logic [1:0] rr_q;

`ifdef RFWC_DROP_CNT_EN
    logic [15:0] drop_q;
    assign drop_cnt = drop_q;
`endif

    // (base + off) mod 3 for base, off in 0..2.
    function automatic logic [1:0] rr_idx(input logic [1:0] base, input logic [1:0] off);
        logic [2:0] s;
        s = {1'b0, base} + {1'b0, off};
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

    // Registers the register file may actually be written at.
    function automatic logic writable(input logic [4:0] a);
        return (a != 5'd0) && (a != SweepHole) && (a <= SweepLast);
    endfunction

    // ------------------------------------------------------------------
    // Round-robin grant: first valid requester at or after rr_q, cyclic.
    // Depends only on req_valid, state and rr pointer, never on addr/data.
    // ------------------------------------------------------------------
    logic       grant_vld;
    logic [1:0] grant_idx;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = 2'd0;
        if (state_q == StRun) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if (!grant_vld && req_valid[rr_idx(rr_q, 2'(i))]) begin
                    grant_vld = 1'b1;
                    grant_idx = rr_idx(rr_q, 2'(i));
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_vld) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Address/data of the granted requester.
    logic [4:0]  sel_addr;
    logic [31:0] sel_data;

    always_comb begin
        sel_addr = req_addr[4:0];
        sel_data = req_data[31:0];
        unique case (grant_idx)
            2'd1: begin
                sel_addr = req_addr[9:5];
                sel_data = req_data[63:32];
            end
            2'd2: begin
                sel_addr = req_addr[14:10];
                sel_data = req_data[95:64];
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM with registered write-port outputs.
    // wp/we/din default to 0 every cycle: the register file zeroes
    // register[wp] whenever wp != 0 with we = 0, so an idle port must
    // present wp = 0.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StClear;
            ptr_q     <= SweepFirst;
            rr_q      <= 2'd0;
            wp        <= 5'd0;
            we        <= 1'b0;
            din       <= 32'd0;
            init_done <= 1'b0;
            err_wr    <= 1'b0;
`ifdef RFWC_DROP_CNT_EN
            drop_q    <= 16'd0;
`endif
        end else begin
            wp     <= 5'd0;
            we     <= 1'b0;
            din    <= 32'd0;
            err_wr <= 1'b0;

            // Lags the state by one cycle so it rises only after the write of
            // register 18 has been issued on the port.
            init_done <= (state_q == StRun);

            unique case (state_q)
                StClear: begin
                    wp <= ptr_q;
                    we <= 1'b1;
                    if (ptr_q == SweepLast) begin
                        state_q <= StRun;
                        ptr_q   <= SweepFirst;
                    end else if (ptr_q == SweepHole - 5'd1) begin
                        ptr_q <= SweepHole + 5'd1;
                    end else begin
                        ptr_q <= ptr_q + 5'd1;
                    end
                end

                StRun: begin
                    if (grant_vld) begin
                        rr_q <= (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
                        if (writable(sel_addr)) begin
                            wp  <= sel_addr;
                            we  <= 1'b1;
                            din <= sel_data;
                        end else begin
                            err_wr <= 1'b1;
`ifdef RFWC_DROP_CNT_EN
                            if (drop_q != 16'hFFFF) begin
                                drop_q <= drop_q + 16'd1;
                            end
`endif
                        end
                    end
                    // The grant made in this cycle still completes; DRAIN then
                    // blocks new grants for one cycle before the sweep restarts.
                    if (clr_req) begin
                        state_q <= StDrain;
                    end
                end

                StDrain: begin
                    state_q <= StClear;
                    ptr_q   <= SweepFirst;
                end

                default: begin
                    state_q <= StClear;
                    ptr_q   <= SweepFirst;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_wr_ctrl.sv
// Testbench for regfile_wr_ctrl. Expected register-file writes are pushed to a
// scoreboard queue as stimulus is applied and popped when the DUT drives we=1.

module tb_regfile_wr_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_valid;
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        clr_req;
    logic [4:0]  wp;
    logic        we;
    logic [31:0] din;
    logic        init_done;
    logic        err_wr;
`ifdef RFWC_DROP_CNT_EN
    logic [15:0] drop_cnt;
    int          exp_drops;
`endif

    always #5 clk = ~clk;

    regfile_wr_ctrl #(.NREQ(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .clr_req   (clr_req),
        .wp        (wp),
        .we        (we),
        .din       (din),
        .init_done (init_done),
        .err_wr    (err_wr)
`ifdef RFWC_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          rr_m = 0;
    logic        drop_pend = 1'b0;
    logic [4:0]  a_m[3];
    logic [31:0] d_m[3];
    logic [31:0] rf[32];

    function automatic int grant_m(input logic [2:0] v, input int rr);
        for (int k = 0; k < 3; k++) begin
            if (v[(rr + k) % 3]) return (rr + k) % 3;
        end
        return -1;
    endfunction

    function automatic logic writable_m(input logic [4:0] a);
        return (a inside {[5'd1:5'd14], [5'd16:5'd18]});
    endfunction

    task automatic set_reqs(input logic [2:0] v);
        req_valid = v;
        req_addr  = {a_m[2], a_m[1], a_m[0]};
        req_data  = {d_m[2], d_m[1], d_m[0]};
    endtask

    task automatic push_wr(input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic push_sweep();
        for (int k = 1; k <= 18; k++) begin
            if (k != 15) push_wr(5'(k), 32'h0);
        end
    endtask

    // One clock: sample registered outputs 2 time units after the edge and
    // reconcile them with the scoreboard and the register-file model.
    task automatic step();
        wr_t e;
        @(posedge clk);
        #2;
        vectors++;
        if (we === 1'b1) begin
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: got wp=%0d din=%h, required no write", wp, din);
            end else begin
                e = exp_q.pop_front();
                if (wp !== e.a || din !== e.d) begin
                    miscompares++;
                    $display("FAIL write: got wp=%0d din=%h, required wp=%0d din=%h",
                             wp, din, e.a, e.d);
                end
            end
        end else if (we !== 1'b0 || wp !== 5'd0 || din !== 32'd0) begin
            miscompares++;
            $display("FAIL idle_port: got we=%b wp=%0d din=%h, required 0/0/0", we, wp, din);
        end
        vectors++;
        if (err_wr !== drop_pend) begin
            miscompares++;
            $display("FAIL err_wr: got %b, required %b", err_wr, drop_pend);
        end
        drop_pend = 1'b0;
        if (we === 1'b1) rf[wp] = din;
        else if (wp !== 5'd0) rf[wp] = 32'd0;
    endtask

    task automatic check_q_empty(input string name);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s: %0d expected writes never seen, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clr_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_m[i] = 5'd0;
            d_m[i] = 32'd0;
        end
        set_reqs(3'b000);
        for (int i = 0; i < 32; i++) rf[i] = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        #2;
        vectors++;
        if (wp !== 5'd0 || we !== 1'b0 || din !== 32'd0 || req_ready !== 3'b000 ||
            init_done !== 1'b0 || err_wr !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_values: got wp=%0d we=%b din=%h ready=%b init=%b err=%b, required 0",
                     wp, we, din, req_ready, init_done, err_wr);
        end
`ifdef RFWC_DROP_CNT_EN
        vectors++;
        if (drop_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_drop_cnt: got %0d, required 0", drop_cnt);
        end
`endif
        rst = 1'b0;
        rr_m = 0;
        push_sweep();
        for (int k = 0; k < 17; k++) begin
            step();
            vectors++;
            if (init_done !== 1'b0) begin
                miscompares++;
                $display("FAIL init_early: sweep cycle %0d got init_done=%b, required 0",
                         k + 1, init_done);
            end
        end
        check_q_empty("sweep_complete");
        step();
        vectors++;
        if (init_done !== 1'b1) begin
            miscompares++;
            $display("FAIL init_done: cycle 18 got %b, required 1", init_done);
        end
        repeat (3) step();
    endtask

    task automatic test_round_robin();
        int g;
        a_m[0] = 5'd3; d_m[0] = 32'hAAAA_0001;
        a_m[1] = 5'd4; d_m[1] = 32'hBBBB_0002;
        a_m[2] = 5'd5; d_m[2] = 32'hCCCC_0003;
        set_reqs(3'b111);
        for (int n = 0; n < 6; n++) begin
            #1;
            g = grant_m(req_valid, rr_m);
            vectors++;
            if (req_ready !== 3'(1 << g)) begin
                miscompares++;
                $display("FAIL rr_grant: cycle %0d got ready=%b, required %b", n, req_ready,
                         3'(1 << g));
            end
            push_wr(a_m[g], d_m[g]);
            rr_m = (g + 1) % 3;
            step();
        end
        set_reqs(3'b000);
        step();
        check_q_empty("rr_writes");
        vectors++;
        if (rf[3] !== 32'hAAAA_0001 || rf[4] !== 32'hBBBB_0002 || rf[5] !== 32'hCCCC_0003) begin
            miscompares++;
            $display("FAIL rr_regs: got %h %h %h, required AAAA0001 BBBB0002 CCCC0003",
                     rf[3], rf[4], rf[5]);
        end
    endtask

    task automatic test_protected();
        int          rq[9]  = '{0, 2, 0, 1, 2, 0, 1, 2, 1};
        logic [4:0]  ad[9]  = '{5'd0, 5'd19, 5'd20, 5'd31, 5'd14, 5'd16, 5'd18, 5'd1, 5'd15};
        for (int n = 0; n < 9; n++) begin
            a_m[rq[n]] = ad[n];
            d_m[rq[n]] = (ad[n] == 5'd15) ? 32'd7 : 32'h100 + 32'(n);
            set_reqs(3'(1 << rq[n]));
            #1;
            vectors++;
            if (req_ready !== 3'(1 << rq[n])) begin
                miscompares++;
                $display("FAIL prot_ready: addr %0d got ready=%b, required %b", ad[n], req_ready,
                         3'(1 << rq[n]));
            end
            if (writable_m(ad[n])) begin
                push_wr(ad[n], d_m[rq[n]]);
            end else begin
                drop_pend = 1'b1;
`ifdef RFWC_DROP_CNT_EN
                exp_drops++;
`endif
            end
            rr_m = (rq[n] + 1) % 3;
            step();
            set_reqs(3'b000);
`ifdef RFWC_DROP_CNT_EN
            vectors++;
            if (drop_cnt !== 16'(exp_drops)) begin
                miscompares++;
                $display("FAIL drop_cnt: after addr %0d got %0d, required %0d", ad[n], drop_cnt,
                         exp_drops);
            end
`endif
        end
        step();
        check_q_empty("prot_writes");
    endtask

    task automatic test_same_addr();
        int g;
        a_m[0] = 5'd9; d_m[0] = 32'h11;
        a_m[2] = 5'd9; d_m[2] = 32'h22;
        set_reqs(3'b101);
        for (int n = 0; n < 2; n++) begin
            #1;
            g = grant_m(req_valid, rr_m);
            vectors++;
            if (req_ready !== 3'(1 << g)) begin
                miscompares++;
                $display("FAIL same_addr_grant: step %0d got ready=%b, required %b", n,
                         req_ready, 3'(1 << g));
            end
            push_wr(a_m[g], d_m[g]);
            rr_m = (g + 1) % 3;
            step();
            set_reqs(req_valid & ~3'(1 << g));
        end
        set_reqs(3'b000);
        repeat (2) step();
        check_q_empty("same_addr_writes");
        vectors++;
        if (rf[9] !== 32'h11) begin
            miscompares++;
            $display("FAIL same_addr_final: got reg9=%h, required 00000011", rf[9]);
        end
    endtask

    task automatic test_clear();
        int g;
        a_m[0] = 5'd3; d_m[0] = 32'h3000;
        a_m[1] = 5'd4; d_m[1] = 32'h4000;
        a_m[2] = 5'd5; d_m[2] = 32'h5000;
        set_reqs(3'b111);
        for (int n = 0; n < 3; n++) begin
            #1;
            g = grant_m(req_valid, rr_m);
            vectors++;
            if (req_ready !== 3'(1 << g)) begin
                miscompares++;
                $display("FAIL clr_pre_grant: cycle %0d got ready=%b, required %b", n,
                         req_ready, 3'(1 << g));
            end
            push_wr(a_m[g], d_m[g]);
            rr_m = (g + 1) % 3;
            if (n == 2) clr_req = 1'b1;
            step();
        end
        // DRAIN cycle; clr_req still high here and must be ignored.
        #1;
        vectors++;
        if (req_ready !== 3'b000) begin
            miscompares++;
            $display("FAIL drain_ready: got %b, required 000", req_ready);
        end
        step();
        clr_req = 1'b0;
        vectors++;
        if (init_done !== 1'b0) begin
            miscompares++;
            $display("FAIL init_fall: got %b, required 0", init_done);
        end
        push_sweep();
        for (int k = 0; k < 17; k++) begin
            clr_req = (k == 5);
            #1;
            vectors++;
            if (req_ready !== 3'b000) begin
                miscompares++;
                $display("FAIL clear_ready: sweep cycle %0d got %b, required 000", k, req_ready);
            end
            step();
        end
        clr_req = 1'b0;
        check_q_empty("resweep");
        for (int n = 0; n < 3; n++) begin
            #1;
            g = grant_m(req_valid, rr_m);
            vectors++;
            if (req_ready !== 3'(1 << g)) begin
                miscompares++;
                $display("FAIL resume_grant: cycle %0d got ready=%b, required %b", n,
                         req_ready, 3'(1 << g));
            end
            push_wr(a_m[g], d_m[g]);
            rr_m = (g + 1) % 3;
            step();
        end
        set_reqs(3'b000);
        step();
        check_q_empty("resume_writes");
        vectors++;
        if (init_done !== 1'b1) begin
            miscompares++;
            $display("FAIL init_resume: got %b, required 1", init_done);
        end
    endtask

    task automatic test_reset_mid_sweep();
        rst = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        rr_m = 0;
        push_sweep();
        repeat (8) step();
        vectors++;
        if (wp !== 5'd8 || we !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_sweep_pos: got wp=%0d we=%b, required 8/1", wp, we);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (wp !== 5'd0 || we !== 1'b0 || din !== 32'd0 || req_ready !== 3'b000 ||
            init_done !== 1'b0 || err_wr !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got wp=%0d we=%b din=%h ready=%b init=%b err=%b, required 0",
                     wp, we, din, req_ready, init_done, err_wr);
        end
        exp_q.delete();
        @(posedge clk);
        #2;
        rst = 1'b0;
        push_sweep();
        repeat (17) step();
        check_q_empty("restart_sweep");
        step();
        vectors++;
        if (init_done !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_init: got %b, required 1", init_done);
        end
    endtask

    initial begin
`ifdef RFWC_DROP_CNT_EN
        exp_drops = 0;
`endif
        test_reset();
        test_round_robin();
        test_protected();
        test_same_addr();
        test_clear();
        test_reset_mid_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
